// File: rtl/mux_4_1_rr_arbiter_if.sv
// -----------------------------------------------------------------------------
// mux_4_1_rr_arbiter_if
//   Bundle between four requesters and the round-robin arbiter that shares
//   one 4:1 multiplexer channel.
//
//   req   [3:0]      request lines, req[k] = requester k wants the channel
//   i     [4*DW-1:0] requester data, requester k at i[k*DW +: DW]
//   gnt   [3:0]      one-hot grant (zero when idle)
//   s     [1:0]      mux select, index of the granted requester
//   valid            a grant is active
//   y     [DW-1:0]   selected data, zero when not valid
//
//   master : requester side (drives req/i, observes the rest)
//   slave  : arbiter side
// -----------------------------------------------------------------------------
interface mux_4_1_rr_arbiter_if #(
  parameter int DW = 1
);
  logic [3:0]      req;
  logic [4*DW-1:0] i;
  logic [3:0]      gnt;
  logic [1:0]      s;
  logic            valid;
  logic [DW-1:0]   y;

  modport master (
    output req, i,
    input  gnt, s, valid, y
  );

  modport slave (
    input  req, i,
    output gnt, s, valid, y
  );
endinterface

// File: rtl/mux_4_1_rr_arbiter.sv
// -----------------------------------------------------------------------------
// mux_4_1_rr_arbiter
//   Round-robin arbiter/sequencer in front of a shared 4:1 mux. One requester
//   holds the channel at a time; a holder that keeps requesting while others
//   wait is rotated out after MAX_HOLD cycles. The grant, select and valid
//   are registered; y is a combinational mux of the live data inputs.
//
//   Parameters
//     DW        data width per requester and of y
//     MAX_HOLD  max consecutive grant cycles under contention (>= 1)
//
//   Ports
//     clk   rising-edge clock
//     rst   synchronous active-high reset
//     bus   slave modport of mux_4_1_rr_arbiter_if (req, i, gnt, s, valid, y)
// -----------------------------------------------------------------------------
module mux_4_1_rr_arbiter #(
  parameter int DW       = 1,
  parameter int MAX_HOLD = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  mux_4_1_rr_arbiter_if.slave   bus
);

  localparam int HCW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HCW-1:0] HOLD_LAST = HCW'(MAX_HOLD - 1);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // First requester with req set, scanning base, base+1, ... wrapping 3 -> 0.
  // Scanning from the far end backwards lets the nearest hit win without a
  // loop exit.
  function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] base);
    logic [1:0] idx;
    pick = base;
    for (int k = 3; k >= 0; k--) begin
      idx = base + 2'(k);
      if (r[idx]) pick = idx;
    end
  endfunction

  state_t          r_state, w_state_nxt;
  logic [1:0]      r_ptr,   w_ptr_nxt;
  logic [HCW-1:0]  r_hold_cnt, w_hold_nxt;
  logic [1:0]      r_s,     w_s_nxt;
  logic [3:0]      r_gnt,   w_gnt_nxt;
  logic            r_valid, w_valid_nxt;

  logic [3:0]      w_g_onehot;
  logic            w_others;
  logic [1:0]      w_g_plus1;

  assign w_g_onehot = 4'b0001 << r_s;
  assign w_others   = |(bus.req & ~w_g_onehot);
  assign w_g_plus1  = r_s + 2'd1;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: state is written with non-blocking assignments so every register
  // samples the pre-edge values of the others; blocking here would make the
  // result depend on statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_ptr      <= 2'd0;
      r_hold_cnt <= '0;
      r_s        <= 2'd0;
      r_gnt      <= 4'b0000;
      r_valid    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_ptr      <= w_ptr_nxt;
      r_hold_cnt <= w_hold_nxt;
      r_s        <= w_s_nxt;
      r_gnt      <= w_gnt_nxt;
      r_valid    <= w_valid_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default first so that no path
    // leaves a value unassigned and infers a latch.
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_hold_nxt  = r_hold_cnt;
    w_s_nxt     = r_s;
    w_gnt_nxt   = r_gnt;
    w_valid_nxt = r_valid;

    unique case (r_state)
      IDLE: begin
        if (|bus.req) begin
          w_s_nxt     = pick(bus.req, r_ptr);
          w_gnt_nxt   = 4'b0001 << pick(bus.req, r_ptr);
          w_valid_nxt = 1'b1;
          w_hold_nxt  = '0;
          w_state_nxt = BUSY;
        end
      end

      BUSY: begin
        if (!bus.req[r_s]) begin
          // Holder released: hand over in the same edge if anyone waits.
          w_ptr_nxt  = w_g_plus1;
          w_hold_nxt = '0;
          if (w_others) begin
            w_s_nxt   = pick(bus.req, w_g_plus1);
            w_gnt_nxt = 4'b0001 << pick(bus.req, w_g_plus1);
          end else begin
            w_gnt_nxt   = 4'b0000;
            w_valid_nxt = 1'b0;
            w_state_nxt = IDLE;
          end
        end else if (!w_others) begin
          // Sole holder keeps the channel; the counter just wraps.
          w_hold_nxt = (r_hold_cnt == HOLD_LAST) ? '0 : r_hold_cnt + 1'b1;
        end else if (r_hold_cnt == HOLD_LAST) begin
          // Forced rotation: mask the holder out so it cannot win again here.
          w_ptr_nxt  = w_g_plus1;
          w_hold_nxt = '0;
          w_s_nxt    = pick(bus.req & ~w_g_onehot, w_g_plus1);
          w_gnt_nxt  = 4'b0001 << pick(bus.req & ~w_g_onehot, w_g_plus1);
        end else begin
          w_hold_nxt = r_hold_cnt + 1'b1;
        end
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs: registered grant/select/valid, live data through the mux
  // ---------------------------------------------------------------------------
  assign bus.gnt   = r_gnt;
  assign bus.s     = r_s;
  assign bus.valid = r_valid;

  always_comb begin
    bus.y = '0;
    if (r_valid) bus.y = bus.i[r_s*DW +: DW];
  end

endmodule

// File: tb/tb_mux_4_1_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mux_4_1_rr_arbiter
//   Directed bench for mux_4_1_rr_arbiter. dut_a uses MAX_HOLD=8, dut_b uses
//   MAX_HOLD=4; both share clk/rst. Inputs change 1 ns after a rising edge and
//   outputs are sampled at that same point, well away from the next edge.
// -----------------------------------------------------------------------------
module tb_mux_4_1_rr_arbiter;

  logic clk;
  logic rst;

  int n_checks = 0;
  int n_fail   = 0;

  mux_4_1_rr_arbiter_if #(.DW(1)) bus_a ();
  mux_4_1_rr_arbiter_if #(.DW(1)) bus_b ();

  mux_4_1_rr_arbiter #(.DW(1), .MAX_HOLD(8)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a.slave)
  );

  mux_4_1_rr_arbiter #(.DW(1), .MAX_HOLD(4)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] i;
    logic [3:0] gnt;
    logic [1:0] s;
    logic       valid;
    logic       y;
    logic       chk_ptr;
    logic [1:0] ptr;
    string      name;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add_vec(input logic r, input logic [3:0] rq, input logic [3:0] d,
                         input logic [3:0] g, input logic [1:0] sel, input logic v,
                         input logic yy, input logic cp, input logic [1:0] p,
                         input string nm);
    vec_t t;
    t.rst = r; t.req = rq; t.i = d; t.gnt = g; t.s = sel; t.valid = v; t.y = yy;
    t.chk_ptr = cp; t.ptr = p; t.name = nm;
    vecs.push_back(t);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst       = 1'b1;
    bus_a.req = 4'b0000;
    bus_a.i   = 4'b0000;
    bus_b.req = 4'b0000;
    bus_b.i   = 4'b0000;

    //       rst req      i        gnt      s  v  y  cp ptr
    add_vec(1, 4'b1111, 4'b1111, 4'b0000, 0, 0, 0, 1, 0, "rst_a");
    add_vec(1, 4'b1111, 4'b1111, 4'b0000, 0, 0, 0, 1, 0, "rst_b");
    add_vec(0, 4'b1111, 4'b0001, 4'b0001, 0, 1, 1, 1, 0, "rst_exit");
    add_vec(0, 4'b0000, 4'b0001, 4'b0000, 0, 0, 0, 1, 1, "release_idle");
    add_vec(0, 4'b0100, 4'b0100, 4'b0100, 2, 1, 1, 1, 1, "single_grant");
    add_vec(0, 4'b0000, 4'b0100, 4'b0000, 2, 0, 0, 1, 3, "single_drop");
    add_vec(0, 4'b1001, 4'b1000, 4'b1000, 3, 1, 1, 1, 3, "wrap_grant3");
    add_vec(0, 4'b1001, 4'b1000, 4'b1000, 3, 1, 1, 1, 3, "wrap_hold1");
    add_vec(0, 4'b1001, 4'b1000, 4'b1000, 3, 1, 1, 1, 3, "wrap_hold2");
    add_vec(0, 4'b0001, 4'b1000, 4'b0001, 0, 1, 0, 1, 0, "wrap_handover");
    add_vec(0, 4'b0001, 4'b0001, 4'b0001, 0, 1, 1, 1, 0, "hold_0");
    add_vec(0, 4'b0000, 4'b0001, 4'b0000, 0, 0, 0, 1, 1, "idle_again");
    add_vec(0, 4'b0110, 4'b0010, 4'b0010, 1, 1, 1, 1, 1, "grant1");
    add_vec(0, 4'b0100, 4'b0010, 4'b0100, 2, 1, 0, 1, 2, "handover2");
    add_vec(0, 4'b0000, 4'b0010, 4'b0000, 2, 0, 0, 1, 3, "idle3");
    add_vec(0, 4'b0011, 4'b0001, 4'b0001, 0, 1, 1, 1, 3, "pick_wrap0");
    add_vec(0, 4'b0101, 4'b0001, 4'b0001, 0, 1, 1, 1, 3, "pending2");
    add_vec(0, 4'b0001, 4'b0001, 4'b0001, 0, 1, 1, 1, 3, "pending2_dropped");
    add_vec(0, 4'b0000, 4'b0001, 4'b0000, 0, 0, 0, 1, 1, "idle_ptr1");

    foreach (vecs[n]) begin
      rst       = vecs[n].rst;
      bus_a.req = vecs[n].req;
      bus_a.i   = vecs[n].i;
      tick();
      check({vecs[n].name, "_gnt"},   32'(bus_a.gnt),   32'(vecs[n].gnt));
      check({vecs[n].name, "_s"},     32'(bus_a.s),     32'(vecs[n].s));
      check({vecs[n].name, "_valid"}, 32'(bus_a.valid), 32'(vecs[n].valid));
      check({vecs[n].name, "_y"},     32'(bus_a.y),     32'(vecs[n].y));
      if (vecs[n].chk_ptr)
        check({vecs[n].name, "_ptr"}, 32'(dut_a.r_ptr), 32'(vecs[n].ptr));
    end

    // Fairness: full contention, each grant lasts exactly 8 cycles, no gaps.
    rst       = 1'b1;
    bus_a.req = 4'b1111;
    bus_a.i   = 4'b0000;
    tick();
    rst = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      int idx;
      tick();
      idx = ((c - 1) / 8) % 4;
      check($sformatf("fair_c%0d_gnt", c),   32'(bus_a.gnt),   32'(4'b0001 << idx));
      check($sformatf("fair_c%0d_s", c),     32'(bus_a.s),     32'(idx));
      check($sformatf("fair_c%0d_valid", c), 32'(bus_a.valid), 32'd1);
    end

    // Reset in the middle of a grant with hold_cnt=5.
    rst       = 1'b1;
    bus_a.req = 4'b0000;
    tick();
    rst       = 1'b0;
    bus_a.req = 4'b0100;
    bus_a.i   = 4'b0100;
    tick();
    for (int c = 0; c < 5; c++) tick();
    check("midrst_pre_gnt",  32'(bus_a.gnt),        32'(4'b0100));
    check("midrst_pre_hold", 32'(dut_a.r_hold_cnt), 32'd5);
    rst       = 1'b1;
    bus_a.req = 4'b1111;
    tick();
    check("midrst_gnt",   32'(bus_a.gnt),   32'd0);
    check("midrst_s",     32'(bus_a.s),     32'd0);
    check("midrst_valid", 32'(bus_a.valid), 32'd0);
    check("midrst_y",     32'(bus_a.y),     32'd0);
    rst = 1'b0;
    tick();
    check("midrst_exit_gnt",   32'(bus_a.gnt),   32'(4'b0001));
    check("midrst_exit_s",     32'(bus_a.s),     32'd0);
    check("midrst_exit_valid", 32'(bus_a.valid), 32'd1);

    // Data path is combinational from i: no clock edge between changes.
    bus_a.i = 4'b0001;
    #1;
    check("comb_y_hi", 32'(bus_a.y), 32'd1);
    bus_a.i = 4'b1110;
    #1;
    check("comb_y_lo", 32'(bus_a.y), 32'd0);

    // Sole holder on the MAX_HOLD=4 instance: grant never drops.
    bus_a.req = 4'b0000;
    bus_b.req = 4'b0010;
    bus_b.i   = 4'b0010;
    for (int c = 1; c <= 20; c++) begin
      tick();
      check($sformatf("sole_c%0d_gnt", c),   32'(bus_b.gnt),   32'(4'b0010));
      check($sformatf("sole_c%0d_valid", c), 32'(bus_b.valid), 32'd1);
    end
    bus_b.req = 4'b0000;
    tick();
    check("sole_release_valid", 32'(bus_b.valid), 32'd0);
    check("sole_release_ptr",   32'(dut_b.r_ptr), 32'd2);

    // Contention on MAX_HOLD=4: starts at 2 (ptr), rotates every 4 cycles.
    bus_b.req = 4'b1111;
    for (int c = 1; c <= 12; c++) begin
      int idx;
      tick();
      idx = (2 + (c - 1) / 4) % 4;
      check($sformatf("rot4_c%0d_gnt", c), 32'(bus_b.gnt), 32'(4'b0001 << idx));
      check($sformatf("rot4_c%0d_s", c),   32'(bus_b.s),   32'(idx));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
